// File: rtl/aoc_grid_pkg.sv
// Shared definitions for the grid loader and the accessibility counter.
// Contents: puzzle character codes, loader state encoding, and the
// decode-class encoding produced by grid_char_decode.
package aoc_grid_pkg;

    localparam logic [7:0] CH_ROLL  = 8'h40;  // '@'
    localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL    = 8'h0A;  // '\n'
    localparam logic [7:0] CH_CR    = 8'h0D;  // '\r'

    typedef enum logic {
        LOAD,
        HOLD
    } load_state_e;

    typedef enum logic [2:0] {
        CELL1,
        CELL0,
        NEWLINE,
        IGNORE,
        BAD
    } char_class_e;

endpackage

// File: rtl/grid_char_decode.sv
// Combinational byte classifier for the puzzle text.
// Ports:
//   in_data - ASCII byte
//   cls     - decode class (CELL1 '@', CELL0 '.', NEWLINE, IGNORE '\r', BAD)
module grid_char_decode
    import aoc_grid_pkg::*;
(
    input  logic [7:0]  in_data,
    output char_class_e cls
);

    always_comb begin
        cls = BAD;
        unique case (in_data)
            CH_ROLL:  cls = CELL1;
            CH_EMPTY: cls = CELL0;
            CH_NL:    cls = NEWLINE;
            CH_CR:    cls = IGNORE;
            default:  cls = BAD;
        endcase
    end

endmodule

// File: rtl/grid_loader.sv
// Byte-stream to bit-matrix loader for the paper-roll accessibility counter.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - byte handshake; in_data is the byte, in_last ends the grid
//   mat[r][c]             - loaded grid, column c at bit c (leftmost char = bit 0)
//   grid_valid / grid_ack - grid complete and frozen / consumer releases it
//   rows, cols            - rows loaded, width of the first non-empty row
//   err                   - sticky format error for the current grid
module grid_loader
    import aoc_grid_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic [WIDTH-1:0]           mat [DEPTH],
    output logic                       grid_valid,
    input  logic                       grid_ack,
    output logic [$clog2(DEPTH+1)-1:0] rows,
    output logic [$clog2(WIDTH+1)-1:0] cols,
    output logic                       err
);

    localparam int RW = $clog2(DEPTH+1);
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH);

    load_state_e   state, state_d;
    char_class_e   cls;
    logic [RW-1:0] row, row_d, rows_d;
    logic [CW-1:0] col, col_d, cols_d;
    logic          err_d;
    logic          set_cell;
    logic          clear_all;
    logic [WIDTH-1:0] col_mask;

    grid_char_decode u_decode (
        .in_data (in_data),
        .cls     (cls)
    );

    assign in_ready = (state == LOAD);

    always_comb begin
        col_mask = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            if (col == CW'(c)) col_mask[c] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        row_d     = row;
        col_d     = col;
        rows_d    = rows;
        cols_d    = cols;
        err_d     = err;
        set_cell  = 1'b0;
        clear_all = 1'b0;
        unique case (state)
            LOAD: begin
                if (in_valid) begin
                    unique case (cls)
                        CELL1, CELL0: begin
                            if (row == ROW_MAX || col == COL_MAX) begin
                                err_d = 1'b1;
                            end else begin
                                set_cell = (cls == CELL1);
                                col_d    = col + 1'b1;
                            end
                        end
                        NEWLINE, IGNORE: ;
                        default: err_d = 1'b1;
                    endcase
                    // in_last acts as an implicit newline, evaluated on the
                    // column count after this beat's own cell was decoded.
                    if ((cls == NEWLINE || in_last) && col_d != '0) begin
                        row_d  = (row == ROW_MAX) ? row : row + 1'b1;
                        rows_d = row_d;
                        col_d  = '0;
                        if (cols == '0) begin
                            cols_d = (cls == NEWLINE) ? col : col_d_pre(col, cls, row, COL_MAX, ROW_MAX);
                        end else if (cur_len(col, cls, row, COL_MAX, ROW_MAX) != cols) begin
                            err_d = 1'b1;
                        end
                    end
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (grid_ack) begin
                    state_d   = LOAD;
                    row_d     = '0;
                    col_d     = '0;
                    rows_d    = '0;
                    cols_d    = '0;
                    err_d     = 1'b0;
                    clear_all = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Row length after decoding the current beat (before any row close).
    function automatic logic [CW-1:0] cur_len(input logic [CW-1:0] c,
                                              input char_class_e k,
                                              input logic [RW-1:0] r,
                                              input logic [CW-1:0] cmax,
                                              input logic [RW-1:0] rmax);
        if ((k == CELL1 || k == CELL0) && r != rmax && c != cmax)
            return c + 1'b1;
        return c;
    endfunction

    function automatic logic [CW-1:0] col_d_pre(input logic [CW-1:0] c,
                                                input char_class_e k,
                                                input logic [RW-1:0] r,
                                                input logic [CW-1:0] cmax,
                                                input logic [RW-1:0] rmax);
        return cur_len(c, k, r, cmax, rmax);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            row        <= '0;
            col        <= '0;
            rows       <= '0;
            cols       <= '0;
            err        <= 1'b0;
            grid_valid <= 1'b0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            col        <= col_d;
            rows       <= rows_d;
            cols       <= cols_d;
            err        <= err_d;
            grid_valid <= (state_d == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) mat[r] <= '0;
        end else if (clear_all) begin
            for (int unsigned r = 0; r < DEPTH; r++) mat[r] <= '0;
        end else if (set_cell) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (row == RW'(r)) mat[r] <= mat[r] | col_mask;
            end
        end
    end

endmodule
